mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch stage (instruction requester) and the memory stage (data load/store requester).
- Replaces the separate IMEM/DMEM instances and the DMEM-preload workaround.
- Sits between the fetch/data-access logic and a variable-latency memory, with one transaction outstanding at a time.
- Data has priority over fetch, with a starvation guard for fetch and a response timeout.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch stage and
// the data stage. Data has priority, fetch is protected by a streak limit, and a
// stalled response is aborted after TIMEOUT cycles with a NOP word and err_o.
module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  // data requester
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  // status
  output logic              err_o,
  output logic              busy_o
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0]     TCNT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [DWIDTH-1:0] NOP_WORD   = DWIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner_d;   // 1 = data stage owns the transaction
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [SW-1:0]     r_streak;
  logic [TW-1:0]     r_tcnt;

  logic              w_gnt_d;
  logic              w_gnt_f;
  logic              w_resp;
  logic              w_mem_done;
  logic              w_tmo;
  logic              w_fin;
  logic [DWIDTH-1:0] w_rdata;

  // IDLE arbitration: data first unless its streak limit is hit while fetch waits.
  always_comb begin
    w_gnt_d = 1'b0;
    w_gnt_f = 1'b0;
    if (rst && (r_state == ST_IDLE)) begin
      if (d_req_i && (r_streak < STREAK_MAX)) begin
        w_gnt_d = 1'b1;
      end else if (if_req_i) begin
        w_gnt_f = 1'b1;
      end else if (d_req_i) begin
        w_gnt_d = 1'b1;
      end else begin
        w_gnt_d = 1'b0;
        w_gnt_f = 1'b0;
      end
    end else begin
      w_gnt_d = 1'b0;
      w_gnt_f = 1'b0;
    end
  end

  // Response completion: a real memory response beats a simultaneous timeout.
  assign w_resp     = rst && (r_state == ST_RESP);
  assign w_mem_done = w_resp && mem_rvalid_i;
  assign w_tmo      = w_resp && !mem_rvalid_i && (r_tcnt == TCNT_LAST);
  assign w_fin      = w_mem_done || w_tmo;

  // Response word: load data, zero for store acks, NOP on abort.
  always_comb begin
    w_rdata = {DWIDTH{1'b0}};
    if (w_mem_done) begin
      if (r_we) begin
        w_rdata = {DWIDTH{1'b0}};
      end else begin
        w_rdata = mem_rdata_i;
      end
    end else if (w_tmo) begin
      w_rdata = NOP_WORD;
    end else begin
      w_rdata = {DWIDTH{1'b0}};
    end
  end

  assign if_gnt_o    = w_gnt_f;
  assign d_gnt_o     = w_gnt_d;
  assign if_rvalid_o = w_fin && !r_owner_d;
  assign d_rvalid_o  = w_fin && r_owner_d;
  assign if_rdata_o  = (w_fin && !r_owner_d) ? w_rdata : {DWIDTH{1'b0}};
  assign d_rdata_o   = (w_fin && r_owner_d) ? w_rdata : {DWIDTH{1'b0}};
  assign err_o       = w_tmo;

  assign mem_req_o   = (r_state == ST_REQ);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = (r_state != ST_IDLE);

  // Transaction FSM: latch the winner, hold the memory request, track timeout and streak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= {AWIDTH{1'b0}};
      r_wdata   <= {DWIDTH{1'b0}};
      r_streak  <= {SW{1'b0}};
      r_tcnt    <= {TW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_d) begin
            r_owner_d <= 1'b1;
            r_we      <= d_we_i;
            r_addr    <= d_addr_i;
            r_wdata   <= d_wdata_i;
            r_state   <= ST_REQ;
            if (if_req_i) begin
              if (r_streak < STREAK_MAX) begin
                r_streak <= r_streak + {{(SW-1){1'b0}}, 1'b1};
              end
            end else begin
              r_streak <= {SW{1'b0}};
            end
          end else if (w_gnt_f) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= if_addr_i;
            r_wdata   <= {DWIDTH{1'b0}};
            r_streak  <= {SW{1'b0}};
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            r_tcnt  <= {TW{1'b0}};
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_fin) begin
            r_state <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by a randomized run against a
// transaction-level model of the arbiter and a bench-owned unified memory.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, d_req_i, d_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
  logic        mem_req_o, mem_we_o, err_o, busy_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_STREAK(MAXS), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge (input drive point)
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle before sampling
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    if_req_i = 1'b0; if_addr_i = 32'h0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = 32'h0; d_wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  // model state for the randomized phase
  logic [31:0] ref_mem [16];
  logic [31:0] phys_mem [16];
  logic        f_pend, d_pend, d_we_m, t_own_d, t_we;
  logic [3:0]  f_idx, d_idx, t_idx, cap_idx;
  logic [31:0] d_wd, t_wd;
  int          ph, req_wait, rsp_wait, streak;
  logic        e_fg, e_dg, e_done;
  logic [9:0]  pat;

  initial begin
    clear_inputs();
    rst = 1'b0;
    // ---------------- reset state
    @(posedge clk); #1;
    settle();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_gnts", {if_gnt_o, d_gnt_o}, 2'b00);
    chk("rst_rvalids", {if_rvalid_o, d_rvalid_o, err_o}, 3'b000);
    nxt();
    rst = 1'b1;
    nxt();

    // ---------------- single fetch
    if_req_i = 1'b1; if_addr_i = 32'h0100_0000;
    settle();
    chk("f_gnt", if_gnt_o, 1'b1);
    chk("f_no_dgnt", d_gnt_o, 1'b0);
    nxt();
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    settle();
    chk("f_mem_req", mem_req_o, 1'b1);
    chk("f_mem_addr", mem_addr_o, 32'h0100_0000);
    chk("f_mem_we", mem_we_o, 1'b0);
    chk("f_busy", busy_o, 1'b1);
    nxt();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0050_0093;
    settle();
    chk("f_rvalid", if_rvalid_o, 1'b1);
    chk("f_rdata", if_rdata_o, 32'h0050_0093);
    chk("f_err", err_o, 1'b0);
    chk("f_mem_req_resp", mem_req_o, 1'b0);
    nxt();
    mem_rvalid_i = 1'b0;
    settle();
    chk("f_idle", busy_o, 1'b0);
    chk("f_rvalid_pulse", if_rvalid_o, 1'b0);

    // ---------------- simultaneous requests
    nxt();
    if_req_i = 1'b1; if_addr_i = 32'h0100_0004;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0100_0200;
    settle();
    chk("sim_dgnt", d_gnt_o, 1'b1);
    chk("sim_no_fgnt", if_gnt_o, 1'b0);
    nxt();
    d_req_i = 1'b0; mem_gnt_i = 1'b1;
    settle();
    chk("sim_req_addr", mem_addr_o, 32'h0100_0200);
    chk("sim_fgnt_busy", if_gnt_o, 1'b0);
    nxt();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1122_3344;
    settle();
    chk("sim_drvalid", d_rvalid_o, 1'b1);
    chk("sim_drdata", d_rdata_o, 32'h1122_3344);
    chk("sim_fgnt_at_rvalid", if_gnt_o, 1'b0);
    nxt();
    mem_rvalid_i = 1'b0;
    settle();
    chk("sim_fgnt_after", if_gnt_o, 1'b1);
    nxt();
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    settle();
    chk("sim_f_addr", mem_addr_o, 32'h0100_0004);
    nxt();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0033;
    settle();
    chk("sim_frvalid", if_rvalid_o, 1'b1);
    nxt();
    mem_rvalid_i = 1'b0;

    // ---------------- store with slow memory
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0100_0100; d_wdata_i = 32'hDEAD_BEEF;
    settle();
    chk("st_gnt", d_gnt_o, 1'b1);
    nxt();
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h5555_5555; d_wdata_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_gnt_i = 1'b1;
      settle();
      chk("st_mem_req", mem_req_o, 1'b1);
      chk("st_mem_we", mem_we_o, 1'b1);
      chk("st_mem_addr", mem_addr_o, 32'h0100_0100);
      chk("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      nxt();
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    settle();
    chk("st_rvalid", d_rvalid_o, 1'b1);
    chk("st_rdata", d_rdata_o, 32'h0);
    nxt();
    mem_rvalid_i = 1'b0;

    // ---------------- starvation guard: D,D,D,D,F,D,D,D,D,F
    pat = 10'b0111101111;
    if_req_i = 1'b1; if_addr_i = 32'h0100_0008;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0100_0300;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("stv_dgnt", d_gnt_o, pat[k]);
      chk("stv_fgnt", if_gnt_o, !pat[k]);
      nxt();
      if (k == 9) begin
        if_req_i = 1'b0; d_req_i = 1'b0;
      end
      mem_gnt_i = 1'b1;
      nxt();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0100 + 32'(k);
      settle();
      chk("stv_owner_rvalid", {d_rvalid_o, if_rvalid_o}, pat[k] ? 2'b10 : 2'b01);
      nxt();
      mem_rvalid_i = 1'b0;
    end

    // ---------------- timeout, then real data in the final RESP cycle
    for (int rep = 0; rep < 2; rep++) begin
      if_req_i = 1'b1; if_addr_i = 32'h0100_0010;
      settle();
      chk("to_gnt", if_gnt_o, 1'b1);
      nxt();
      if_req_i = 1'b0; mem_gnt_i = 1'b1;
      nxt();
      mem_gnt_i = 1'b0;
      for (int i = 0; i < 64; i++) begin
        if (rep == 1 && i == 63) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        end
        settle();
        if (i < 63) begin
          chk("to_wait_rvalid", if_rvalid_o, 1'b0);
          chk("to_wait_busy", busy_o, 1'b1);
        end else if (rep == 0) begin
          chk("to_rvalid", if_rvalid_o, 1'b1);
          chk("to_nop", if_rdata_o, 32'h0000_0013);
          chk("to_err", err_o, 1'b1);
        end else begin
          chk("to_late_rvalid", if_rvalid_o, 1'b1);
          chk("to_late_data", if_rdata_o, 32'hCAFE_F00D);
          chk("to_late_err", err_o, 1'b0);
        end
        nxt();
      end
      mem_rvalid_i = 1'b0;
      settle();
      chk("to_idle_busy", busy_o, 1'b0);
      chk("to_idle_err", err_o, 1'b0);
      chk("to_idle_rvalid", if_rvalid_o, 1'b0);
      nxt();
    end

    // ---------------- reset mid-transaction
    if_req_i = 1'b1; if_addr_i = 32'h0100_0020;
    nxt();
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    nxt();
    mem_gnt_i = 1'b0;
    nxt();
    rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    settle();
    chk("rm_busy", busy_o, 1'b0);
    chk("rm_mem_req", mem_req_o, 1'b0);
    chk("rm_outs", {if_rvalid_o, d_rvalid_o, err_o, if_gnt_o, d_gnt_o}, 5'b00000);
    chk("rm_rdata", if_rdata_o, 32'h0);
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rm_after_rvalid", {if_rvalid_o, d_rvalid_o, err_o}, 3'b000);
      chk("rm_after_busy", busy_o, 1'b0);
      nxt();
    end
    clear_inputs();

    // ---------------- randomized run against the transaction model
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = 32'hA5A5_0000 ^ (32'h0101_0101 * 32'(i));
      phys_mem[i] = ref_mem[i];
    end
    f_pend = 1'b0; d_pend = 1'b0; d_we_m = 1'b0; f_idx = 4'd0; d_idx = 4'd0; d_wd = 32'h0;
    t_own_d = 1'b0; t_we = 1'b0; t_idx = 4'd0; t_wd = 32'h0; cap_idx = 4'd0;
    ph = 0; req_wait = 0; rsp_wait = 0; streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!f_pend && $urandom_range(0, 1) == 0) begin
        f_pend = 1'b1; f_idx = 4'($urandom_range(0, 15));
      end
      if (d_pend && $urandom_range(0, 7) == 0) begin
        d_pend = 1'b0;
      end else if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1'b1; d_we_m = 1'($urandom_range(0, 1));
        d_idx = 4'($urandom_range(0, 15)); d_wd = $urandom;
      end
      if_req_i  = f_pend;
      if_addr_i = f_pend ? (BASE + {26'd0, f_idx, 2'b00}) : $urandom;
      d_req_i   = d_pend;
      d_we_i    = d_pend ? d_we_m : 1'($urandom_range(0, 1));
      d_addr_i  = d_pend ? (BASE + {26'd0, d_idx, 2'b00}) : $urandom;
      d_wdata_i = d_pend ? d_wd : $urandom;
      mem_gnt_i = (ph == 1) && (req_wait == 0);
      if (ph == 2) begin
        mem_rvalid_i = (rsp_wait == 0);
        mem_rdata_i  = t_we ? $urandom : phys_mem[cap_idx];
      end else begin
        mem_rvalid_i = ($urandom_range(0, 3) == 0);
        mem_rdata_i  = $urandom;
      end
      settle();

      e_fg = 1'b0; e_dg = 1'b0;
      if (ph == 0) begin
        if (d_pend && streak < MAXS) e_dg = 1'b1;
        else if (f_pend) e_fg = 1'b1;
        else if (d_pend) e_dg = 1'b1;
      end
      e_done = (ph == 2) && (rsp_wait == 0);
      chk("r_if_gnt", if_gnt_o, e_fg);
      chk("r_d_gnt", d_gnt_o, e_dg);
      chk("r_if_rvalid", if_rvalid_o, e_done && !t_own_d);
      chk("r_d_rvalid", d_rvalid_o, e_done && t_own_d);
      chk("r_err", err_o, 1'b0);
      chk("r_busy", busy_o, ph != 0);
      chk("r_mem_req", mem_req_o, ph == 1);
      if (e_done && !t_own_d) chk("r_if_rdata", if_rdata_o, ref_mem[t_idx]);
      if (e_done && t_own_d) chk("r_d_rdata", d_rdata_o, t_we ? 32'h0 : ref_mem[t_idx]);
      if (ph == 1) begin
        chk("r_mem_addr", mem_addr_o, BASE + {26'd0, t_idx, 2'b00});
        chk("r_mem_we", mem_we_o, t_we);
        if (t_we) chk("r_mem_wdata", mem_wdata_o, t_wd);
      end

      case (ph)
        0: begin
          if (e_dg) begin
            t_own_d = 1'b1; t_we = d_we_m; t_idx = d_idx; t_wd = d_wd;
            if (d_we_m) ref_mem[d_idx] = d_wd;
            streak = f_pend ? ((streak < MAXS) ? streak + 1 : streak) : 0;
            d_pend = 1'b0; ph = 1; req_wait = $urandom_range(0, 2);
          end else if (e_fg) begin
            t_own_d = 1'b0; t_we = 1'b0; t_idx = f_idx; t_wd = 32'h0;
            streak = 0; f_pend = 1'b0; ph = 1; req_wait = $urandom_range(0, 2);
          end
        end
        1: begin
          if (req_wait == 0) begin
            cap_idx = mem_addr_o[5:2];
            if (mem_we_o) phys_mem[cap_idx] = mem_wdata_o;
            ph = 2; rsp_wait = $urandom_range(0, 5);
          end else begin
            req_wait = req_wait - 1;
          end
        end
        2: begin
          if (rsp_wait == 0) ph = 0;
          else rsp_wait = rsp_wait - 1;
        end
        default: ph = 0;
      endcase
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
